uart_rx: RTL

- 8N1 UART receiver. Counterpart to the uart_tx transmitter in the same serial link.
- Oversamples the asynchronous serial line with the system clock and samples each bit at its midpoint.
- Outputs each received byte with a one-cycle valid strobe. Reports a bad stop bit with a one-cycle framing-error strobe.
- Sits between the board RX pin and the consumer logic (command decoder / FIFO).

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling driven by a
// 16-bit bit-period counter, one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [15:0] HALF = 16'((CLK_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEAN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_rx_s;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  r_data;
  logic [7:0]  w_data_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_ferr;
  logic        w_ferr_nxt;
  logic        r_busy;
  logic        w_busy_nxt;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end

      // Re-check the start bit at its midpoint so short glitches are dropped.
      S_START: begin
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          if (r_idx == 3'd7) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CLEAN;
          if (w_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      // A held-low line (break) must go high before a new start is accepted.
      S_CLEAN: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_busy      = r_busy;

endmodule
